// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared types and constants for the multi-channel clock divider.
// Optional feature macro: CLK_DIV_SYNC_EN (adds a global channel-restart input).
package clk_div_pkg;

    // Default build parameters; modules may override them.
    localparam int unsigned N_CH_DEF     = 4;
    localparam int unsigned WIDTH_DEF    = 32;
    localparam int unsigned DIV_INIT_DEF = 50_000_000;

    // Channel-select width, never narrower than one bit.
    function automatic int unsigned chan_w(input int unsigned n);
        if (n > 1) begin
            return $clog2(n);
        end else begin
            return 1;
        end
    endfunction

    localparam int unsigned CHAN_W_DEF = chan_w(N_CH_DEF);

    typedef logic [CHAN_W_DEF-1:0] chan_idx_t;
    typedef logic [WIDTH_DEF-1:0]  div_t;

    // A divisor of zero parks the channel with its outputs low.
    localparam div_t DIV_STOP = {WIDTH_DEF{1'b0}};

endpackage

// File: rtl/clk_div_multi_if.sv
// clk_div_multi_if: divisor configuration handshake (valid/ready, channel, divisor).
// Optional feature macro: CLK_DIV_SYNC_EN (not used by this interface).
interface clk_div_multi_if
    import clk_div_pkg::*;
#(
    parameter int unsigned N_CH  = N_CH_DEF,
    parameter int unsigned WIDTH = WIDTH_DEF
);
    localparam int unsigned CW = chan_w(N_CH);

    logic             cfg_valid;
    logic             cfg_ready;
    logic [CW-1:0]    cfg_chan;
    logic [WIDTH-1:0] cfg_div;

    modport master (
        output cfg_valid,
        output cfg_chan,
        output cfg_div,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_chan,
        input  cfg_div,
        output cfg_ready
    );

endinterface

// File: rtl/clk_div_chan.sv
// clk_div_chan: one divider channel with a double-buffered half-period divisor.
// A new divisor waits in the shadow register and is applied only at a period
// boundary (or immediately when idle), so the square wave never glitches.
// Optional feature macro: CLK_DIV_SYNC_EN (drives sync_i from the top).
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int unsigned WIDTH    = WIDTH_DEF,
    parameter int unsigned DIV_INIT = DIV_INIT_DEF
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             sync_i,
    input  logic             en_i,
    input  logic             wr_i,
    input  logic [WIDTH-1:0] wr_div_i,
    output logic             clk_div_o,
    output logic             tick_o,
    output logic             pending_o
);
    localparam logic [WIDTH-1:0] DIV_RST = WIDTH'(DIV_INIT);
    localparam logic [WIDTH-1:0] STOP_W  = WIDTH'(DIV_STOP);
    localparam logic [WIDTH-1:0] ONE_W   = WIDTH'(1);
    localparam logic [WIDTH-1:0] ZERO_W  = WIDTH'(0);

    logic [WIDTH-1:0] count_q,   count_d;
    logic [WIDTH-1:0] div_act_q, div_act_d;
    logic [WIDTH-1:0] div_shd_q, div_shd_d;
    logic             pending_q, pending_d;
    logic             clk_div_q, clk_div_d;
    logic             tick_q,    tick_d;

    logic running_s;
    logic wrap_s;

    // Running / end-of-half-period detection; >= keeps a lowered divisor safe.
    always_comb begin
        running_s = 1'b0;
        wrap_s    = 1'b0;
        if (en_i && (div_act_q != STOP_W)) begin
            running_s = 1'b1;
            if (count_q >= (div_act_q - ONE_W)) begin
                wrap_s = 1'b1;
            end else begin
                wrap_s = 1'b0;
            end
        end else begin
            running_s = 1'b0;
            wrap_s    = 1'b0;
        end
    end

    // Next-state: sync restart, run/wrap, idle, then capture of a new divisor.
    always_comb begin
        count_d   = count_q;
        div_act_d = div_act_q;
        div_shd_d = div_shd_q;
        pending_d = pending_q;
        clk_div_d = clk_div_q;
        tick_d    = 1'b0;

        if (sync_i || !running_s || wrap_s) begin
            // Every boundary (restart, idle cycle, wrap) is an apply point.
            count_d = ZERO_W;
            if (pending_q) begin
                div_act_d = div_shd_q;
                pending_d = 1'b0;
            end else begin
                div_act_d = div_act_q;
                pending_d = pending_q;
            end
            if (sync_i || !running_s) begin
                clk_div_d = 1'b0;
                tick_d    = 1'b0;
            end else begin
                clk_div_d = ~clk_div_q;
                tick_d    = 1'b1;
            end
        end else begin
            count_d = count_q + ONE_W;
            tick_d  = 1'b0;
        end

        // A write is only accepted while nothing is pending, so it never
        // collides with an apply on the same edge.
        if (wr_i) begin
            div_shd_d = wr_div_i;
            pending_d = 1'b1;
        end else begin
            div_shd_d = div_shd_d;
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count_q   <= ZERO_W;
            div_act_q <= DIV_RST;
            div_shd_q <= DIV_RST;
            pending_q <= 1'b0;
            clk_div_q <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            count_q   <= count_d;
            div_act_q <= div_act_d;
            div_shd_q <= div_shd_d;
            pending_q <= pending_d;
            clk_div_q <= clk_div_d;
            tick_q    <= tick_d;
        end
    end

    assign clk_div_o = clk_div_q;
    assign tick_o    = tick_q;
    assign pending_o = pending_q;

endmodule

// File: rtl/clk_div_multi.sv
// clk_div_multi: N_CH-channel programmable square-wave / tick generator.
// Decodes configuration writes, muxes cfg_ready from the addressed channel's
// pending flag, and instantiates one clk_div_chan per channel.
// Optional feature macro: CLK_DIV_SYNC_EN (adds input sync to restart all channels).
module clk_div_multi
    import clk_div_pkg::*;
#(
    parameter int unsigned N_CH     = N_CH_DEF,
    parameter int unsigned WIDTH    = WIDTH_DEF,
    parameter int unsigned DIV_INIT = DIV_INIT_DEF
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [N_CH-1:0]     en,
    clk_div_multi_if.slave      cfg,
    output logic [N_CH-1:0]     clk_div,
    output logic [N_CH-1:0]     tick
`ifdef CLK_DIV_SYNC_EN
    ,
    input  logic                sync
`endif
);
    localparam int unsigned CW   = chan_w(N_CH);
    localparam int unsigned NPAD = 1 << CW;

    logic [N_CH-1:0] pend_s;
    logic [N_CH-1:0] wr_s;
    logic [NPAD-1:0] pend_pad_s;
    logic            cfg_ready_s;
    logic            sync_s;

`ifdef CLK_DIV_SYNC_EN
    assign sync_s = sync;
`else
    assign sync_s = 1'b0;
`endif

    // Pad pending flags to the full select range; unused selects read as
    // "not pending", so writes to them are accepted and dropped.
    always_comb begin
        pend_pad_s = {NPAD{1'b0}};
        for (int c = 0; c < N_CH; c++) begin
            pend_pad_s[c] = pend_s[c];
        end
    end

    assign cfg_ready_s   = ~pend_pad_s[cfg.cfg_chan];
    assign cfg.cfg_ready = cfg_ready_s;

    // One-hot write strobe for the addressed channel on an accepted transfer.
    always_comb begin
        wr_s = {N_CH{1'b0}};
        for (int c = 0; c < N_CH; c++) begin
            if (cfg.cfg_valid && cfg_ready_s && (cfg.cfg_chan == CW'(c))) begin
                wr_s[c] = 1'b1;
            end else begin
                wr_s[c] = 1'b0;
            end
        end
    end

    for (genvar c = 0; c < N_CH; c++) begin : g_chan
        clk_div_chan #(
            .WIDTH    (WIDTH),
            .DIV_INIT (DIV_INIT)
        ) u_chan (
            .clk       (clk),
            .reset_n   (reset_n),
            .sync_i    (sync_s),
            .en_i      (en[c]),
            .wr_i      (wr_s[c]),
            .wr_div_i  (cfg.cfg_div),
            .clk_div_o (clk_div[c]),
            .tick_o    (tick[c]),
            .pending_o (pend_s[c])
        );
    end

endmodule

// File: tb/tb_clk_div_multi.sv
// tb_clk_div_multi: randomized + directed bench for clk_div_multi against a
// timestamp-based reference model (each channel remembers the edge at which
// its current half-period began and toggles when D edges have elapsed).
// Optional feature macro: CLK_DIV_SYNC_EN (exercises the sync input).
module tb_clk_div_multi;
    import clk_div_pkg::*;

    localparam int N_CH     = 5;
    localparam int WIDTH    = 16;
    localparam int DIV_INIT = 4;

    logic            clk = 1'b0;
    logic            reset_n;
    logic [N_CH-1:0] en;
    logic [N_CH-1:0] clk_div;
    logic [N_CH-1:0] tick;
`ifdef CLK_DIV_SYNC_EN
    logic            sync;
`endif

    clk_div_multi_if #(.N_CH(N_CH), .WIDTH(WIDTH)) cfg_bus ();

    always #5 clk = ~clk;

    clk_div_multi #(
        .N_CH     (N_CH),
        .WIDTH    (WIDTH),
        .DIV_INIT (DIV_INIT)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (en),
        .cfg     (cfg_bus),
        .clk_div (clk_div),
        .tick    (tick)
`ifdef CLK_DIV_SYNC_EN
        ,
        .sync    (sync)
`endif
    );

    // ---------------- reference model ----------------
    int unsigned m_act   [N_CH];
    int unsigned m_shd   [N_CH];
    bit          m_pend  [N_CH];
    bit          m_lvl   [N_CH];
    bit          m_tk    [N_CH];
    int          m_start [N_CH];
    int          n_edge  = 0;
    bit          m_valid = 1'b0;
    bit          m_acc   = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at edge %0d: got %0h expected %0h", tag, n_edge, got, exp);
        end
    endtask

    function automatic bit model_ready(input int ch);
        if (ch >= N_CH) return 1'b1;
        return !m_pend[ch];
    endfunction

    // Advance the model by one rising edge using the inputs held before it.
    task automatic model_step();
        bit s;
        int ch;
        n_edge++;
        s = 1'b0;
`ifdef CLK_DIV_SYNC_EN
        s = sync;
`endif
        ch = int'(cfg_bus.cfg_chan);
        if (!reset_n) begin
            m_acc = 1'b0;
            for (int c = 0; c < N_CH; c++) begin
                m_act[c] = DIV_INIT; m_shd[c] = DIV_INIT; m_pend[c] = 1'b0;
                m_lvl[c] = 1'b0; m_tk[c] = 1'b0; m_start[c] = n_edge;
            end
            m_valid = 1'b1;
        end else begin
            m_acc = cfg_bus.cfg_valid && model_ready(ch);
            for (int c = 0; c < N_CH; c++) begin
                bit boundary;
                boundary = 1'b1;
                if (s) begin
                    m_lvl[c] = 1'b0; m_tk[c] = 1'b0;
                end else if (en[c] && m_act[c] != 0) begin
                    if (n_edge - m_start[c] >= int'(m_act[c])) begin
                        m_lvl[c] = !m_lvl[c]; m_tk[c] = 1'b1;
                    end else begin
                        m_tk[c] = 1'b0; boundary = 1'b0;
                    end
                end else begin
                    m_lvl[c] = 1'b0; m_tk[c] = 1'b0;
                end
                if (boundary) begin
                    m_start[c] = n_edge;
                    if (m_pend[c]) begin
                        m_act[c] = m_shd[c]; m_pend[c] = 1'b0;
                    end
                end
                if (m_acc && ch == c) begin
                    m_shd[c] = int'(cfg_bus.cfg_div); m_pend[c] = 1'b1;
                end
            end
        end
    endtask

    // One clock: check handshake before the edge, outputs just after it.
    task automatic cycle();
        logic [N_CH-1:0] e_div, e_tick;
        #1;
        if (m_valid) check_eq("cfg_ready", 32'(cfg_bus.cfg_ready),
                              32'(model_ready(int'(cfg_bus.cfg_chan))));
        @(posedge clk);
        model_step();
        #1;
        for (int c = 0; c < N_CH; c++) begin
            e_div[c] = m_lvl[c]; e_tick[c] = m_tk[c];
        end
        check_eq("clk_div", 32'(clk_div), 32'(e_div));
        check_eq("tick", 32'(tick), 32'(e_tick));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    // Hold a write until the model says it was accepted (bounded wait).
    task automatic cfg_write(input int ch, input int dv);
        bit done;
        done = 1'b0;
        cfg_bus.cfg_valid = 1'b1;
        cfg_bus.cfg_chan  = 3'(ch);
        cfg_bus.cfg_div   = 16'(dv);
        for (int k = 0; k < 64 && !done; k++) begin
            cycle();
            done = m_acc;
        end
        check_eq("cfg_accept", 32'(done), 32'd1);
        cfg_bus.cfg_valid = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0;
        en      = {N_CH{1'b0}};
        cfg_bus.cfg_valid = 1'b0;
        cfg_bus.cfg_chan  = 3'd0;
        cfg_bus.cfg_div   = 16'd0;
`ifdef CLK_DIV_SYNC_EN
        sync = 1'b0;
`endif
        run(2);
        check_eq("rst_ready", 32'(cfg_bus.cfg_ready), 32'd1);
        check_eq("rst_clk_div", 32'(clk_div), 32'd0);

        // All channels at the reset divisor.
        reset_n = 1'b1;
        en = {N_CH{1'b1}};
        run(20);

        // Lower channel 1 mid-period; old half-period completes first.
        reset_n = 1'b0; run(1); reset_n = 1'b1;
        run(1);
        cfg_write(1, 2);
        run(16);

        // Back-to-back writes to channel 0: the second stalls.
        cfg_write(0, 10);
        cfg_write(0, 7);
        run(40);

        // Stop channel 2, then run it at divisor 1.
        cfg_write(2, 0);
        run(10);
        cfg_write(2, 1);
        run(8);

        // Enable gap on channel 3, then a mid-period reset.
        run(2);
        en[3] = 1'b0; run(3); en[3] = 1'b1;
        run(10);
        reset_n = 1'b0; run(1); reset_n = 1'b1;
        run(12);

        // Out-of-range channel: accepted and discarded.
        cfg_write(6, 3);
        run(6);

`ifdef CLK_DIV_SYNC_EN
        cfg_write(0, 3);
        cfg_write(1, 5);
        run(7);
        sync = 1'b1; run(1); sync = 1'b0;
        run(12);
`endif

        // Randomized traffic.
        for (int i = 0; i < 700; i++) begin
            if ($urandom_range(0, 7) == 0) en[$urandom_range(0, N_CH-1)] = ($urandom_range(0, 3) != 0);
            cfg_bus.cfg_valid = ($urandom_range(0, 2) == 0);
            cfg_bus.cfg_chan  = 3'($urandom_range(0, 7));
            cfg_bus.cfg_div   = 16'($urandom_range(0, 9));
            reset_n = ($urandom_range(0, 199) != 0);
`ifdef CLK_DIV_SYNC_EN
            sync = ($urandom_range(0, 49) == 0);
`endif
            cycle();
        end
        cfg_bus.cfg_valid = 1'b0;
        reset_n = 1'b1;
        run(4);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
